// File: rtl/dcache_line_serializer.sv
// rtl/dcache_line_serializer.sv - splits cache line fills/writebacks into bus-width memory beats
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   dcache_req_i         line request, held by the cache until dcache_ack_o
//   dcache_we_i          1 = writeback, 0 = fill
//   dcache_addr_i        line address (offset bits ignored)
//   dcache_wdata_i       writeback line
//   dcache_rdata_o       assembled fill line (registered, held between fills)
//   dcache_ack_o         one-cycle line-complete pulse
//   bus_req_o/we_o       beat request / write enable
//   bus_addr_o           beat byte address
//   bus_wdata_o/sel_o    beat write data / byte enables
//   bus_rdata_i/ack_i    beat read data / beat complete (may be combinational to bus_req_o)

module dcache_line_serializer #(
  parameter int LINE_WIDTH = 128,
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    dcache_req_i,
  input  logic                    dcache_we_i,
  input  logic [ADDR_WIDTH-1:0]   dcache_addr_i,
  input  logic [LINE_WIDTH-1:0]   dcache_wdata_i,
  output logic [LINE_WIDTH-1:0]   dcache_rdata_o,
  output logic                    dcache_ack_o,
  output logic                    bus_req_o,
  output logic                    bus_we_o,
  output logic [ADDR_WIDTH-1:0]   bus_addr_o,
  output logic [BUS_WIDTH-1:0]    bus_wdata_o,
  output logic [BUS_WIDTH/8-1:0]  bus_sel_o,
  input  logic [BUS_WIDTH-1:0]    bus_rdata_i,
  input  logic                    bus_ack_i
);

  localparam int BEATS     = LINE_WIDTH / BUS_WIDTH;
  localparam int OFF_BITS  = $clog2(LINE_WIDTH / 8);
  localparam int BYTE_BITS = $clog2(BUS_WIDTH / 8);
  // A single-beat line still needs a one-bit counter to keep the declarations legal.
  localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BEAT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic                    we_q, we_d;
  logic [LINE_WIDTH-1:0]   wline_q, wline_d;
  logic [LINE_WIDTH-1:0]   rline_q, rline_d;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      we_q    <= we_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  // Next state and register updates. Cache-side inputs are only looked at in
  // IDLE, so a transfer in flight always runs to its last beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    we_d    = we_q;
    wline_d = wline_q;
    rline_d = rline_q;
    case (state_q)
      S_IDLE: begin
        if (dcache_req_i) begin
          // Masking keeps base aligned; low bits are never stored.
          base_d  = dcache_addr_i & ~OFF_MASK;
          we_d    = dcache_we_i;
          wline_d = dcache_wdata_i;
          cnt_d   = '0;
          state_d = S_BEAT;
        end
      end
      S_BEAT: begin
        if (bus_ack_i) begin
          if (!we_q) begin
            rline_d[cnt_q*BUS_WIDTH +: BUS_WIDTH] = bus_rdata_i;
          end
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs depend only on registers; nothing from dcache_* reaches the bus
  // without passing through a flop.
  always_comb begin
    bus_req_o    = 1'b0;
    bus_we_o     = 1'b0;
    bus_addr_o   = '0;
    bus_wdata_o  = '0;
    bus_sel_o    = '0;
    dcache_ack_o = 1'b0;
    case (state_q)
      S_BEAT: begin
        bus_req_o  = 1'b1;
        bus_we_o   = we_q;
        bus_sel_o  = '1;
        // base offset bits are zero, so OR-ing in the beat index forms the address.
        bus_addr_o = base_q | (ADDR_WIDTH'(cnt_q) << BYTE_BITS);
        if (we_q) begin
          bus_wdata_o = wline_q[cnt_q*BUS_WIDTH +: BUS_WIDTH];
        end
      end
      S_DONE: begin
        dcache_ack_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign dcache_rdata_o = rline_q;

endmodule

// File: tb/tb_dcache_line_serializer.sv
// tb/tb_dcache_line_serializer.sv - scoreboard bench for dcache_line_serializer

module tb_dcache_line_serializer;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         dcache_req_i;
  logic         dcache_we_i;
  logic [31:0]  dcache_addr_i;
  logic [127:0] dcache_wdata_i;
  logic [127:0] dcache_rdata_o;
  logic         dcache_ack_o;
  logic         bus_req_o;
  logic         bus_we_o;
  logic [31:0]  bus_addr_o;
  logic [31:0]  bus_wdata_o;
  logic [3:0]   bus_sel_o;
  logic [31:0]  bus_rdata_i;
  logic         bus_ack_i;

  dcache_line_serializer dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .dcache_req_i   (dcache_req_i),
    .dcache_we_i    (dcache_we_i),
    .dcache_addr_i  (dcache_addr_i),
    .dcache_wdata_i (dcache_wdata_i),
    .dcache_rdata_o (dcache_rdata_o),
    .dcache_ack_o   (dcache_ack_o),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_sel_o      (bus_sel_o),
    .bus_rdata_i    (bus_rdata_i),
    .bus_ack_i      (bus_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [127:0] rdata;
    int           cyc;
  } line_t;

  beat_t       bq[$];
  line_t       lq[$];
  logic [31:0] rq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wait_cfg = 0;
  int wcnt = 0;
  logic force_ack = 1'b0;

  always @(posedge clk_i) cyc++;

  // Memory model: acks each beat after wait_cfg wait cycles; read data comes from rq.
  always begin
    @(posedge clk_i);
    #2;
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;
    if (rst_ni && bus_req_o) begin
      if (wcnt == wait_cfg) begin
        bus_ack_i = 1'b1;
        wcnt = 0;
        if (!bus_we_o && rq.size() > 0) bus_rdata_i = rq.pop_front();
        else bus_rdata_i = 32'hDEAD_BEEF;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
      if (force_ack) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h5A5A_5A5A;
      end
    end
  end

  // Monitor: every cycle a beat is presented it must match the queue head; an
  // ack retires it. Every line ack must match the next expected line.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (bus_req_o) begin
        total++;
        if (bq.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected addr=%h we=%b", bus_addr_o, bus_we_o);
        end else begin
          if (bus_addr_o !== bq[0].addr || bus_we_o !== bq[0].we ||
              bus_wdata_o !== bq[0].wdata || bus_sel_o !== 4'hF) begin
            bad++;
            $display("FAIL beat got addr=%h we=%b wdata=%h sel=%h want addr=%h we=%b wdata=%h sel=f",
                     bus_addr_o, bus_we_o, bus_wdata_o, bus_sel_o,
                     bq[0].addr, bq[0].we, bq[0].wdata);
          end
          if (bus_ack_i) void'(bq.pop_front());
        end
      end
      if (dcache_ack_o) begin
        total++;
        if (lq.size() == 0) begin
          bad++;
          $display("FAIL line_ack_unexpected cyc=%0d", cyc);
        end else begin
          line_t e;
          e = lq.pop_front();
          if (dcache_rdata_o !== e.rdata || cyc != e.cyc) begin
            bad++;
            $display("FAIL line_ack got rdata=%h cyc=%0d want rdata=%h cyc=%0d",
                     dcache_rdata_o, cyc, e.rdata, e.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic push_beats(input logic [31:0] base, input logic we, input logic [127:0] line);
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      b.addr  = base + 32'(4 * i);
      b.we    = we;
      b.wdata = we ? line[i*32 +: 32] : 32'h0;
      bq.push_back(b);
    end
  endtask

  task automatic push_line(input logic [127:0] rdata, input int c);
    line_t l;
    l.rdata = rdata;
    l.cyc   = c;
    lq.push_back(l);
  endtask

  // Drives a request just after a rising edge; returns that cycle's number.
  task automatic start(input logic we, input logic [31:0] addr, input logic [127:0] wdata,
                       output int p);
    @(posedge clk_i);
    #1;
    dcache_req_i   = 1'b1;
    dcache_we_i    = we;
    dcache_addr_i  = addr;
    dcache_wdata_i = wdata;
    p = cyc;
  endtask

  task automatic wait_ack(input string name);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      if (dcache_ack_o) seen = 1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got=no_ack want=ack", name);
    end
  endtask

  localparam logic [127:0] FILL_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] WB_B   = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] FILL_C = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;
  localparam logic [127:0] FILL_D = 128'h24242424_23232323_22222222_21212121;
  localparam logic [127:0] WB_D   = 128'h3D3D3D3D_3C3C3C3C_3B3B3B3B_3A3A3A3A;
  localparam logic [127:0] FILL_F = 128'h64646464_63636363_62626262_61616161;

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    rst_ni = 1'b0;
    dcache_req_i = 1'b0;
    dcache_we_i = 1'b0;
    dcache_addr_i = 32'h0;
    dcache_wdata_i = 128'h0;
    bus_rdata_i = 32'h0;
    bus_ack_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #3;
    check("reset_outputs", {dcache_ack_o, bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, 128'h0);
    check("reset_rdata", dcache_rdata_o, 128'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check("idle_no_req", {127'h0, bus_req_o}, 128'h0);

    // Zero-wait fill
    wait_cfg = 0;
    rq = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    push_beats(32'h8000_1230, 1'b0, 128'h0);
    start(1'b0, 32'h8000_1234, 128'h0, p);
    push_line(FILL_A, p + 5);
    wait_ack("fill_a");
    dcache_req_i = 1'b0;

    // Writeback with two wait cycles per beat
    wait_cfg = 2;
    push_beats(32'h0000_0040, 1'b1, WB_B);
    start(1'b1, 32'h0000_0040, WB_B, p);
    push_line(FILL_A, p + 13);
    wait_ack("wb_b");
    dcache_req_i = 1'b0;
    @(negedge clk_i);
    check("wb_keeps_rdata", dcache_rdata_o, FILL_A);

    // Request dropped and inputs changed after beat 1
    wait_cfg = 1;
    rq = '{32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 32'h0D0D0D0D};
    push_beats(32'h0000_1000, 1'b0, 128'h0);
    start(1'b0, 32'h0000_1000, 128'h0, p);
    push_line(FILL_C, p + 9);
    repeat (5) @(posedge clk_i);
    #1;
    dcache_req_i = 1'b0;
    dcache_addr_i = 32'hFFFF_FFF0;
    dcache_we_i = 1'b1;
    dcache_wdata_i = '1;
    wait_ack("drop_c");
    repeat (3) @(negedge clk_i);

    // Back-to-back: request held across the ack starts a second transaction
    wait_cfg = 0;
    rq = '{32'h21212121, 32'h22222222, 32'h23232323, 32'h24242424};
    push_beats(32'h0000_2000, 1'b0, 128'h0);
    push_beats(32'h0000_3000, 1'b1, WB_D);
    start(1'b0, 32'h0000_2000, 128'h0, p);
    push_line(FILL_D, p + 5);
    push_line(FILL_D, p + 11);
    @(posedge clk_i);
    #1;
    dcache_we_i = 1'b1;
    dcache_addr_i = 32'h0000_3008;
    dcache_wdata_i = WB_D;
    wait_ack("b2b_first");
    wait_ack("b2b_second");
    dcache_req_i = 1'b0;

    // Spurious bus ack in IDLE is ignored
    @(posedge clk_i);
    #1;
    force_ack = 1'b1;
    repeat (3) @(negedge clk_i);
    check("spurious_no_req", {127'h0, bus_req_o}, 128'h0);
    check("spurious_rdata", dcache_rdata_o, FILL_D);
    force_ack = 1'b0;

    // Reset asserted mid-cycle during beat 2 of a fill
    wait_cfg = 1;
    rq = '{32'hE1E1E1E1, 32'hE2E2E2E2, 32'hE3E3E3E3, 32'hE4E4E4E4};
    push_beats(32'h0000_5000, 1'b0, 128'h0);
    start(1'b0, 32'h0000_5000, 128'h0, p);
    repeat (5) @(posedge clk_i);
    #3;
    check("pre_reset_beat2_addr", {96'h0, bus_addr_o}, 128'h5008);
    rst_ni = 1'b0;
    dcache_req_i = 1'b0;
    #1;
    check("async_reset_outputs", {dcache_ack_o, bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, 128'h0);
    check("async_reset_rline", dcache_rdata_o, 128'h0);
    bq.delete();
    lq.delete();
    rq.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    check("post_reset_idle", {126'h0, bus_req_o, dcache_ack_o}, 128'h0);

    // Fresh fill after reset starts at beat 0
    wait_cfg = 0;
    rq = '{32'h61616161, 32'h62626262, 32'h63636363, 32'h64646464};
    push_beats(32'h0000_6000, 1'b0, 128'h0);
    start(1'b0, 32'h0000_600C, 128'h0, p);
    push_line(FILL_F, p + 5);
    wait_ack("fill_f");
    dcache_req_i = 1'b0;
    repeat (3) @(negedge clk_i);

    check("beats_all_seen", 128'(bq.size()), 128'h0);
    check("lines_all_seen", 128'(lq.size()), 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
